// File: rtl/comp4_chk.sv
// Self-checking monitor for a 4-bit magnitude comparator: scores each valid
// {l,g,e} triple against the unsigned compare of A and B across a counted run.
module comp4_chk #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [CW-1:0] num,
   input  logic          vld,
   input  logic [3:0]    A,
   input  logic [3:0]    B,
   input  logic          l,
   input  logic          g,
   input  logic          e,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic          err,
   output logic          ill,
   output logic [CW-1:0] pcnt,
   output logic [CW-1:0] fcnt,
   output logic [3:0]    fa,
   output logic [3:0]    fb,
   output logic [2:0]    fres
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] num_q, num_d;
   logic [CW-1:0] chk_q, chk_d;
   logic [CW-1:0] pcnt_q, pcnt_d;
   logic [CW-1:0] fcnt_q, fcnt_d;
   logic          err_q, err_d;
   logic          ill_q, ill_d;
   logic [3:0]    fa_q, fa_d;
   logic [3:0]    fb_q, fb_d;
   logic [2:0]    fres_q, fres_d;
   logic          busy_q, done_q, pass_q;

   logic [2:0]    obs, expv;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == '1) ? v : v + CW'(1);
   endfunction

   assign obs  = {l, g, e};
   assign expv = {A < B, A > B, A == B};

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      chk_d   = chk_q;
      pcnt_d  = pcnt_q;
      fcnt_d  = fcnt_q;
      err_d   = err_q;
      ill_d   = ill_q;
      fa_d    = fa_q;
      fb_d    = fb_q;
      fres_d  = fres_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               num_d   = num;
               chk_d   = '0;
               pcnt_d  = '0;
               fcnt_d  = '0;
               err_d   = 1'b0;
               ill_d   = 1'b0;
               fa_d    = '0;
               fb_d    = '0;
               fres_d  = '0;
            end
         end
         RUN: begin
            // An empty run finishes on the cycle after entry without scoring anything.
            if (num_q == '0) begin
               state_d = DONE;
            end else if (vld) begin
               chk_d = chk_q + CW'(1);
               if (obs == expv) begin
                  pcnt_d = sat_inc(pcnt_q);
               end else begin
                  fcnt_d = sat_inc(fcnt_q);
                  err_d  = 1'b1;
                  if (!err_q) begin
                     fa_d   = A;
                     fb_d   = B;
                     fres_d = obs;
                  end
               end
               if (!$onehot(obs))
                  ill_d = 1'b1;
               if (chk_d == num_q)
                  state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         num_q   <= '0;
         chk_q   <= '0;
         pcnt_q  <= '0;
         fcnt_q  <= '0;
         err_q   <= 1'b0;
         ill_q   <= 1'b0;
         fa_q    <= '0;
         fb_q    <= '0;
         fres_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         chk_q   <= chk_d;
         pcnt_q  <= pcnt_d;
         fcnt_q  <= fcnt_d;
         err_q   <= err_d;
         ill_q   <= ill_d;
         fa_q    <= fa_d;
         fb_q    <= fb_d;
         fres_q  <= fres_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
         pass_q  <= (state_d == DONE) && (fcnt_d == '0);
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign pass = pass_q;
   assign err  = err_q;
   assign ill  = ill_q;
   assign pcnt = pcnt_q;
   assign fcnt = fcnt_q;
   assign fa   = fa_q;
   assign fb   = fb_q;
   assign fres = fres_q;

endmodule

// File: tb/tb_comp4_chk.sv
// Scoreboard bench for comp4_chk: a behavioural reference pushes expected
// outputs every clock; they are popped and compared on the falling edge.
module tb_comp4_chk;

   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n, start, vld, l, g, e;
   logic [CW-1:0] num;
   logic [3:0]    A, B;
   logic          busy, done, pass, err, ill;
   logic [CW-1:0] pcnt, fcnt;
   logic [3:0]    fa, fb;
   logic [2:0]    fres;

   comp4_chk #(.CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num(num), .vld(vld),
      .A(A), .B(B), .l(l), .g(g), .e(e),
      .busy(busy), .done(done), .pass(pass), .err(err), .ill(ill),
      .pcnt(pcnt), .fcnt(fcnt), .fa(fa), .fb(fb), .fres(fres)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, expv);
      end
   endtask

   // Reference model, deliberately written with plain integers.
   int   m_st = 0;  // 0 idle, 1 run, 2 done
   int   m_num = 0, m_cnt = 0, m_p = 0, m_f = 0;
   int   m_fa = 0, m_fb = 0, m_fres = 0;
   bit   m_err = 0, m_ill = 0, good, started = 0;
   logic [31:0] sb_q[$];

   always @(posedge clk) begin
      started = 1;
      if (!rst_n) begin
         m_st = 0; m_num = 0; m_cnt = 0; m_p = 0; m_f = 0;
         m_err = 0; m_ill = 0; m_fa = 0; m_fb = 0; m_fres = 0;
      end else if (m_st != 1) begin
         if (start) begin
            m_st = 1; m_num = int'(num); m_cnt = 0; m_p = 0; m_f = 0;
            m_err = 0; m_ill = 0; m_fa = 0; m_fb = 0; m_fres = 0;
         end
      end else if (m_num == 0) begin
         m_st = 2;
      end else if (vld) begin
         good = (l == (A < B)) && (g == (A > B)) && (e == (A == B));
         if (good) begin
            m_p = (m_p < 255) ? m_p + 1 : 255;
         end else begin
            if (!m_err) begin
               m_fa = int'(A); m_fb = int'(B); m_fres = int'({l, g, e});
            end
            m_err = 1;
            m_f = (m_f < 255) ? m_f + 1 : 255;
         end
         if (int'(l) + int'(g) + int'(e) != 1) m_ill = 1;
         m_cnt++;
         if (m_cnt == m_num) m_st = 2;
      end
      sb_q.push_back({m_st == 1, m_st == 2, (m_st == 2) && (m_f == 0), m_err, m_ill,
                      8'(m_p), 8'(m_f), 4'(m_fa), 4'(m_fb), 3'(m_fres)});
   end

   always @(negedge clk) begin
      if (started) begin
         check("sb_depth", sb_q.size(), 1);
         if (sb_q.size() > 0)
            check("cyc", {busy, done, pass, err, ill, pcnt, fcnt, fa, fb, fres}, sb_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n);
      start = 1'b1;
      num   = CW'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic vec(input int a, input int b, input logic [2:0] lge);
      A = 4'(a);
      B = 4'(b);
      {l, g, e} = lge;
      vld = 1'b1;
      tick();
      vld = 1'b0;
   endtask

   function automatic logic [2:0] ok(input int a, input int b);
      return {a < b, a > b, a == b};
   endfunction

   task automatic wait_done(input string tag, input int budget);
      int i = 0;
      while (!done && i < budget) begin
         tick();
         i++;
      end
      check(tag, done, 1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; vld = 1'b0; num = '0;
      A = '0; B = '0; l = 1'b0; g = 1'b0; e = 1'b0;
      tick();
      tick();
      check("rst_outs", {busy, done, pass, err, ill, pcnt, fcnt, fa, fb, fres}, 0);
      rst_n = 1'b1;
      vec(3, 3, 3'b111);
      check("idle_vld_ill", ill, 0);
      check("idle_vld_fcnt", fcnt, 0);

      // Correct comparator, with a start pulse mid-run that must be ignored.
      do_start(15);
      check("s1_busy", busy, 1);
      for (int b = 2; b <= 6; b++) vec(1, b, ok(1, b));
      start = 1'b1; num = 8'd2; tick(); start = 1'b0;
      check("s1_start_ign", pcnt, 5);
      for (int b = 0; b <= 4; b++) vec(5, b, ok(5, b));
      for (int a = 1; a <= 5; a++) vec(a, a, ok(a, a));
      check("s1_done", done, 1);
      check("s1_busy_lo", busy, 0);
      check("s1_pass", pass, 1);
      check("s1_pcnt", pcnt, 15);
      check("s1_fcnt", fcnt, 0);
      check("s1_err", err, 0);

      do_start(3);
      vec(5, 2, 3'b010);
      vec(3, 3, 3'b100);
      vec(1, 4, 3'b100);
      check("s2_done", done, 1);
      check("s2_fcnt", fcnt, 1);
      check("s2_pcnt", pcnt, 2);
      check("s2_err", err, 1);
      check("s2_fa", fa, 3);
      check("s2_fb", fb, 3);
      check("s2_fres", fres, 3'b100);
      check("s2_pass", pass, 0);

      do_start(2);
      vec(4, 4, 3'b011);
      vec(0, 15, 3'b000);
      check("s3_ill", ill, 1);
      check("s3_fcnt", fcnt, 2);
      check("s3_fa", fa, 4);
      check("s3_fb", fb, 4);
      check("s3_fres", fres, 3'b011);

      do_start(0);
      check("s4_busy", busy, 1);
      check("s4_done0", done, 0);
      tick();
      check("s4_done", done, 1);
      check("s4_busy_lo", busy, 0);
      check("s4_pass", pass, 1);
      check("s4_cnts", {pcnt, fcnt}, 0);

      // 255 + 45 failing vectors over two runs.
      do_start(255);
      for (int i = 0; i < 255; i++) vec(0, 1, 3'b010);
      wait_done("s5_done", 4);
      check("s5_fcnt", fcnt, 255);
      check("s5_pcnt", pcnt, 0);
      vec(0, 1, 3'b010);
      check("s5_done_vld_ign", fcnt, 255);
      do_start(45);
      check("s5_restart_fcnt", fcnt, 0);
      check("s5_restart_busy", busy, 1);
      for (int i = 0; i < 45; i++) vec(0, 1, 3'b010);
      wait_done("s5_done2", 4);
      check("s5_fcnt2", fcnt, 45);

      do_start(10);
      for (int i = 0; i < 5; i++) vec(i, 15 - i, ok(i, 15 - i));
      check("s6_mid_pcnt", pcnt, 5);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("s6_rst_outs", {busy, done, pass, err, ill, pcnt, fcnt, fa, fb, fres}, 0);
      vec(2, 2, 3'b001);
      check("s6_vld_ign", {pcnt, fcnt}, 0);
      do_start(1);
      check("s6_fresh", pcnt, 0);
      vec(7, 9, 3'b100);
      check("s6_done", done, 1);
      check("s6_pass", pass, 1);
      check("s6_pcnt", pcnt, 1);

      tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
